// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion FSM states, GF(2^8) doubling and AES-128 constants.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        SUB  = 2'd2,
        MIX  = 2'd3
    } state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         AES128_NR = 10;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational: d = SubBytes(a), zero latency.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign d = SBOX[a];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule sharing one S-box: one round key per 6 cycles, first key 1 cycle after ld.
// Round keys are offered on a valid/ready handshake; rk_ready low holds the current key indefinitely.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t      state;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [7:0]  rcon;
    logic [1:0]  bcnt;
    logic [3:0]  round;

    logic [31:0] rot_w3;
    logic [7:0]  sbox_a;
    logic [7:0]  sbox_d;
    logic [31:0] w0_nxt, w1_nxt, w2_nxt, w3_nxt;

    assign rot_w3 = {w3[23:0], w3[31:24]};

    always_comb begin
        sbox_a = rot_w3[31:24];
        case (bcnt)
            2'd0: sbox_a = rot_w3[31:24];
            2'd1: sbox_a = rot_w3[23:16];
            2'd2: sbox_a = rot_w3[15:8];
            2'd3: sbox_a = rot_w3[7:0];
            default: sbox_a = rot_w3[31:24];
        endcase
    end

    aes_sbox u_sbox (
        .a (sbox_a),
        .d (sbox_d)
    );

    // Each word chains on the freshly updated word before it.
    assign w0_nxt = w0 ^ temp ^ {rcon, 24'h0};
    assign w1_nxt = w1 ^ w0_nxt;
    assign w2_nxt = w2 ^ w1_nxt;
    assign w3_nxt = w3 ^ w2_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            temp  <= '0;
            rcon  <= RCON_INIT;
            bcnt  <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld) begin
                // A reload abandons whatever round key is pending, including the last one.
                w0    <= key[127:96];
                w1    <= key[95:64];
                w2    <= key[63:32];
                w3    <= key[31:0];
                round <= '0;
                rcon  <= RCON_INIT;
                bcnt  <= '0;
                state <= OUT;
            end else begin
                case (state)
                    OUT: begin
                        if (rk_ready) begin
                            if (round == LAST_ROUND) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= SUB;
                                bcnt  <= '0;
                            end
                        end
                    end
                    SUB: begin
                        case (bcnt)
                            2'd0: temp[31:24] <= sbox_d;
                            2'd1: temp[23:16] <= sbox_d;
                            2'd2: temp[15:8]  <= sbox_d;
                            2'd3: temp[7:0]   <= sbox_d;
                            default: temp[31:24] <= sbox_d;
                        endcase
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            state <= MIX;
                        end
                    end
                    MIX: begin
                        w0    <= w0_nxt;
                        w1    <= w1_nxt;
                        w2    <= w2_nxt;
                        w3    <= w3_nxt;
                        round <= round + 4'd1;
                        rcon  <= xtime(rcon);
                        state <= OUT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rk       = {w0, w1, w2, w3};
    assign rk_round = round;
    assign rk_valid = (state == OUT);
    assign busy     = (state != IDLE);

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Sequential AES-128 key expansion. Loads a 128-bit cipher key and generates round keys 0..NR one at a time.
- Each round key is delivered over a valid/ready handshake.
- Time-multiplexes one aes_sbox instance: the four SubWord lookups take 4 cycles per round.
- Sits upstream of the sbox: drives its address and consumes its data. Feeds round keys to the cipher/inverse-cipher datapath.

Parameters:
- NR, 10, number of expanded rounds after round key 0. Only 10 (AES-128) is verified.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ld  in  1  load pulse; samples key and (re)starts expansion.
- key  in  128  cipher key; byte 0 = key[127:120].
- rk  out  128  current round key; word 0 = rk[127:96].
- rk_round  out  4  index of the round key on rk (0..NR).
- rk_valid  out  1  rk / rk_round are valid.
- rk_ready  in  1  consumer accepts rk this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after round NR is accepted.

Behaviour:
- Reset (rst low, async):
  - State IDLE; w0..w3, temp, rk = 0; rk_round = 0.
  - rcon = 8'h01; byte counter = 0; rk_valid = busy = done = 0.
- State register: w0..w3 (32 b each), temp (32 b), rcon (8 b), bcnt (2 b), round (4 b).
- States: IDLE, OUT, SUB, MIX.
- ld has priority in every state:
  - Captures key into w0..w3; round = 0; rcon = 8'h01; bcnt = 0; next state OUT.
  - Any pending round key is abandoned and no done pulse is issued.
- OUT:
  - rk_valid = 1; rk = {w0,w1,w2,w3}; rk_round = round.
  - rk and rk_round stay stable while rk_ready is low.
  - On rk_valid & rk_ready: if round == NR, go to IDLE and pulse done next cycle. Otherwise go to SUB with bcnt = 0.
- SUB (4 cycles, bcnt 0..3):
  - sbox address = byte of RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}, selected by bcnt (0 = MSB byte).
  - Sbox data is registered into temp byte bcnt (temp[31:24] for bcnt 0). Lookup is combinational, same cycle.
  - After bcnt == 3, go to MIX.
- MIX (1 cycle):
  - w0' = w0 ^ temp ^ {rcon, 24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - round += 1; rcon = xtime(rcon), i.e. (rcon << 1) ^ (rcon[7] ? 8'h1b : 0). Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Next state OUT.
- rk_valid is 0 in IDLE, SUB and MIX.
- Latency:
  - ld at cycle t gives rk_valid at t+1.
  - With rk_ready held high, consecutive round keys are 6 cycles apart: handshake, 4 SUB, 1 MIX.
  - Full schedule: round 10 handshake at t+61; done at t+62.
- busy is high in OUT, SUB and MIX.
- Back-pressure: rk_ready low in OUT stalls indefinitely with no state change.
- rk_ready while rk_valid is low is ignored.
- ld in the same cycle as a final handshake: ld wins; done is not pulsed.

Decomposition:
- Shared package aes_pkg:
  - state enum (IDLE, OUT, SUB, MIX).
  - xtime function.
  - constants RCON_INIT = 8'h01 and AES128_NR = 10.
- Sub-module: one instance of the existing aes_sbox (a -> d).
- No other hierarchy.

Test Plan:
- Reset: assert rst low mid-SUB -> all outputs 0, state IDLE, async (no clock edge needed); release, no activity until ld.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = key at t+1.
  - round 1 = a0fafe1788542cb123a339392a6c7605 at t+7.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+61.
  - done pulse at t+62; busy low at t+62.
- All-zero key:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-pressure: random rk_ready (about 30% high) on the FIPS key -> identical 11-key sequence, rk stable while stalled, no dropped or duplicated rk_round.
- Reload mid-expansion: ld with the zero key during round 4 SUB -> next rk_valid at +1 cycle with rk_round=0 and rk=0; no done from the aborted run.
- ld coincident with the round-10 handshake -> no done; restart from the new key.
